// File: rtl/mic1_pkg.sv
// Shared widths, MIR field positions and sequencer state encoding for the
// Mic-1 style micro-sequencer.
package mic1_pkg;
  localparam int MPC_W    = 9;
  localparam int MIR_W    = 36;
  localparam int NA_HI    = 35;
  localparam int NA_LO    = 27;
  localparam int JMPC_BIT = 26;
  localparam int JAMN_BIT = 25;
  localparam int JAMZ_BIT = 24;

  localparam logic [MPC_W-1:0] RESET_MPC = 9'h000;
  localparam logic [MPC_W-1:0] HALT_ADDR = 9'h1FF;

  typedef enum logic [1:0] {FETCH, LOAD, EXEC, HALT} seq_state_e;
endpackage

// File: rtl/mpc_next_logic.sv
// Combinational next-MPC: NEXT_ADDRESS with JAMN/JAMZ OR-ed into bit 8 and
// an optional MBR OR-dispatch on the low byte (no carries anywhere).
module mpc_next_logic
  import mic1_pkg::*;
(
  input  logic [MIR_W-1:0] mir,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic [7:0]       mbr,
  output logic [MPC_W-1:0] next
);
  logic [MPC_W-1:0] na;

  assign na        = mir[NA_HI:NA_LO];
  assign next[8]   = na[8] | (mir[JAMN_BIT] & alu_n) | (mir[JAMZ_BIT] & alu_z);
  assign next[7:0] = mir[JMPC_BIT] ? (na[7:0] | mbr) : na[7:0];
endmodule

// File: rtl/micro_sequencer.sv
// Three-phase micro-sequencer: FETCH issues the control-store read, LOAD
// captures the word into mir, EXEC retires it (or stalls on mem_busy).
module micro_sequencer
  import mic1_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  output logic             cs_ren,
  output logic [MPC_W-1:0] cs_raddr,
  input  logic [MIR_W-1:0] cs_rdata,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic [7:0]       mbr,
  input  logic             mem_busy,
  input  logic             halt_req,
  output logic [MIR_W-1:0] mir,
  output logic             mir_exec,
  output logic             halted,
  output logic [15:0]      ucount
);
  seq_state_e       state;
  logic [MPC_W-1:0] mpc;
  logic [MPC_W-1:0] next;

  mpc_next_logic u_next (
    .mir   (mir),
    .alu_n (alu_n),
    .alu_z (alu_z),
    .mbr   (mbr),
    .next  (next)
  );

  assign cs_ren   = (state == FETCH);
  assign cs_raddr = mpc;
  // Commit is same-cycle on mem_busy so the datapath never sees a stale strobe
  assign mir_exec = (state == EXEC) && !mem_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FETCH;
      mpc    <= RESET_MPC;
      mir    <= '0;
      ucount <= '0;
      halted <= 1'b0;
    end else begin
      case (state)
        FETCH: state <= LOAD;
        LOAD: begin
          mir   <= cs_rdata;
          state <= EXEC;
        end
        EXEC: begin
          // halt_req only matters on the retiring edge
          if (!mem_busy) begin
            mpc    <= next;
            ucount <= ucount + 16'd1;
            if (next == HALT_ADDR || halt_req) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_micro_sequencer.sv
// Randomized scoreboard bench: an instruction-level model predicts fetch
// addresses, committed words and retire counts with their cycle numbers.
module tb_micro_sequencer;
  import mic1_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_ren;
  logic [8:0]  cs_raddr;
  logic [35:0] cs_rdata = '0;
  logic        alu_n, alu_z, mem_busy, halt_req;
  logic [7:0]  mbr;
  logic [35:0] mir;
  logic        mir_exec, halted;
  logic [15:0] ucount;

  micro_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cs_ren(cs_ren), .cs_raddr(cs_raddr),
    .cs_rdata(cs_rdata), .alu_n(alu_n), .alu_z(alu_z), .mbr(mbr),
    .mem_busy(mem_busy), .halt_req(halt_req), .mir(mir),
    .mir_exec(mir_exec), .halted(halted), .ucount(ucount)
  );

  always #5 clk = ~clk;

  logic [35:0] cstore [512];
  always @(posedge clk) if (cs_ren) cs_rdata <= cstore[cs_raddr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [8:0] addr; } fetch_t;
  typedef struct { int cyc; logic [35:0] word; logic [15:0] cnt; } exec_t;
  fetch_t fq[$];
  exec_t  eq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int m_mpc, m_cnt;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Monitor: every cs_ren / mir_exec must match the next queued expectation
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (cs_ren) begin
        if (fq.size() == 0) fail_now("unexpected cs_ren");
        else begin
          fetch_t f;
          f = fq.pop_front();
          check("fetch cycle", cyc, f.cyc);
          check("fetch addr", cs_raddr, f.addr);
        end
      end
      if (mir_exec) begin
        if (eq.size() == 0) fail_now("unexpected mir_exec");
        else begin
          exec_t e;
          e = eq.pop_front();
          check("exec cycle", cyc, e.cyc);
          check("exec mir", mir, e.word);
          check("exec ucount", ucount, e.cnt);
        end
      end
    end
  end

  task automatic drive_noise(bit busy);
    alu_n    = 1'($urandom);
    alu_z    = 1'($urandom);
    mbr      = 8'($urandom);
    halt_req = 1'($urandom);
    mem_busy = busy;
  endtask

  function automatic logic [35:0] word(int na, bit j, bit n, bit z);
    logic [31:0] r;
    logic [8:0]  a;
    r = $urandom;
    a = 9'(na);
    return {a, j, n, z, r[23:0]};
  endfunction

  // One microinstruction starting at a negedge in FETCH; returns at the next
  // FETCH/HALT negedge. Next address is worked out from the field rules.
  task automatic run_uinstr(int stalls, bit n, bit z, logic [7:0] b, bit hreq,
                            output bit halt);
    logic [35:0] w;
    int na, hi, lo, nxt;
    fq.push_back('{cyc, m_mpc[8:0]});
    drive_noise(1'($urandom)); @(negedge clk);
    drive_noise(1'($urandom)); @(negedge clk);
    repeat (stalls) begin drive_noise(1'b1); @(negedge clk); end
    alu_n = n; alu_z = z; mbr = b; halt_req = hreq; mem_busy = 1'b0;
    w = cstore[m_mpc];
    eq.push_back('{cyc, w, m_cnt[15:0]});
    na  = int'(w[35:27]);
    hi  = ((na >= 256) || (w[25] && n) || (w[24] && z)) ? 1 : 0;
    lo  = na % 256;
    if (w[26]) lo = lo | int'(b);
    nxt = hi * 256 + lo;
    m_mpc = nxt;
    m_cnt = (m_cnt + 1) % 65536;
    halt  = (nxt == 511) || hreq;
    @(negedge clk);
  endtask

  task automatic after_halt();
    for (int i = 0; i < 4; i++) begin
      drive_noise(1'($urandom));
      #2;
      check("halted", halted, 1);
      check("halt mpc held", cs_raddr, m_mpc);
      check("halt ucount held", ucount, m_cnt);
      check("halt no exec", mir_exec, 0);
      @(negedge clk);
    end
    rst_n = 1'b0;
  endtask

  // Fetch, load, two stalls, then async reset in the middle of the stall
  task automatic abort_uinstr();
    fq.push_back('{cyc, m_mpc[8:0]});
    drive_noise(1'($urandom)); @(negedge clk);
    drive_noise(1'($urandom)); @(negedge clk);
    drive_noise(1'b1); @(negedge clk);
    drive_noise(1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("abort cs_raddr", cs_raddr, 0);
    check("abort ucount", ucount, 0);
    check("abort mir", mir, 0);
    check("abort halted", halted, 0);
    check("abort mir_exec", mir_exec, 0);
    check("abort cs_ren", cs_ren, 1);
    fq.delete();
    eq.delete();
  endtask

  task automatic start_episode();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_mpc = 0;
    m_cnt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bit h;
    logic [63:0] r;
    drive_noise(1'b0);
    for (int i = 0; i < 512; i++) begin
      r = {$urandom, $urandom};
      cstore[i] = r[35:0];
    end
    #3;
    check("reset cs_ren", cs_ren, 1);
    check("reset cs_raddr", cs_raddr, 0);
    check("reset mir", mir, 0);
    check("reset mir_exec", mir_exec, 0);
    check("reset halted", halted, 0);
    check("reset ucount", ucount, 0);

    // Directed walk: 000 -> 005 -> 110 -> 036 -> 0AA -> 010 -> 1FF (halt)
    cstore[9'h000] = word(9'h005, 0, 0, 0);
    cstore[9'h005] = word(9'h010, 0, 0, 1);
    cstore[9'h110] = word(9'h000, 1, 0, 0);
    cstore[9'h036] = word(9'h0AA, 0, 0, 0);
    cstore[9'h0AA] = word(9'h010, 0, 0, 1);
    cstore[9'h010] = word(9'h1FF, 0, 0, 0);
    start_episode();
    run_uinstr(0, 0, 0, 8'h00, 0, h);
    check("dir next 005", cs_raddr, 9'h005);
    check("dir ucount 1", ucount, 1);
    run_uinstr(0, 0, 1, 8'h00, 0, h);
    check("dir jamz set", cs_raddr, 9'h110);
    run_uinstr(0, 1, 1, 8'h36, 0, h);
    check("dir jmpc", cs_raddr, 9'h036);
    run_uinstr(4, 0, 0, 8'h00, 0, h);
    check("dir stall ucount", ucount, 4);
    run_uinstr(0, 1, 0, 8'hFF, 0, h);
    check("dir jamz clear", cs_raddr, 9'h010);
    run_uinstr(0, 0, 0, 8'h00, 0, h);
    check("dir halt flag", h, 1);
    after_halt();

    for (int ep = 0; ep < 8; ep++) begin
      for (int i = 0; i < 512; i++) begin
        r = {$urandom, $urandom};
        cstore[i] = r[35:0];
      end
      start_episode();
      h = 1'b0;
      for (int k = 0; k < 40 && !h; k++)
        run_uinstr(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4),
                   1'($urandom), 1'($urandom), 8'($urandom),
                   $urandom_range(0, 29) == 0, h);
      if (h) after_halt();
      else abort_uinstr();
    end

    @(negedge clk);
    check("fetch queue drained", fq.size(), 0);
    check("exec queue drained", eq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
